// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a two-state IDLE/GRANT FSM.
// A grant is issued only from IDLE, lasts until the grantee signals done,
// drops its request, or has held the resource for HOLD_MAX cycles.
// Scanning resumes just after the last grantee, so every requester is
// eventually served.
module rr_arbiter #(
    parameter int N        = 16,
    parameter int HOLD_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] gnt,
    output logic [3:0]   gnt_id,
    output logic         gnt_valid,
    output logic         timeout,
    output logic         idle_flag
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] ptr;
    logic [3:0] hold_cnt;

    logic       hi_found;
    logic [3:0] hi_id;
    logic       lo_found;
    logic [3:0] lo_id;
    logic       sel_found;
    logic [3:0] sel_id;

    logic       cur_req;
    logic       hold_hit;
    logic       release_now;

    // Round-robin pick: lowest set bit above ptr, else lowest set bit at or below ptr
    always_comb begin
        hi_found = 1'b0;
        hi_id    = 4'd0;
        lo_found = 1'b0;
        lo_id    = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (i > int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_id    = 4'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_id    = 4'(i);
                end
            end
        end
        sel_found = hi_found | lo_found;
        sel_id    = hi_found ? hi_id : lo_id;
    end

    // gnt is one-hot on the grantee, so masking req with it tests req[gnt_id]
    assign cur_req     = |(req & gnt);
    assign hold_hit    = (hold_cnt == 4'(HOLD_MAX));
    assign release_now = done | ~cur_req | hold_hit;

    assign idle_flag = (state == IDLE) && (req == '0);

    // FSM, grant registers, pointer and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 4'(N - 1);
            hold_cnt  <= 4'd0;
            gnt       <= '0;
            gnt_id    <= 4'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && sel_found) begin
                        state     <= GRANT;
                        gnt       <= {{(N-1){1'b0}}, 1'b1} << sel_id;
                        gnt_id    <= sel_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= 4'd1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state     <= IDLE;
                        ptr       <= gnt_id;
                        gnt       <= '0;
                        gnt_id    <= 4'd0;
                        gnt_valid <= 1'b0;
                        hold_cnt  <= 4'd0;
                        // only a pure age-out is flagged; a concurrent normal release wins
                        timeout   <= hold_hit & ~done & cur_req;
                    end else begin
                        hold_cnt  <= hold_cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=16, HOLD_MAX=8): rotation, age-out,
// mid-grant release, enable gating and reset during a grant.
module tb_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;
    logic        idle_flag;

    int n_assert;
    int n_fail;

    rr_arbiter #(.N(16), .HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .idle_flag (idle_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst  = 1'b1;
        en   = 1'b0;
        req  = 16'h0000;
        done = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_id", 32'(gnt_id), 32'h0);
        chk("rst_valid", 32'(gnt_valid), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_idle", 32'(idle_flag), 32'h1);
        rst = 1'b0;
        tick();
        chk("idle_after_rst", 32'(idle_flag), 32'h1);

        // rotation between ends of the vector, done in 2nd grant cycle
        req = 16'h8001;
        en  = 1'b1;
        #1;
        chk("idle_flag_req", 32'(idle_flag), 32'h0);
        tick();
        chk("g0_gnt", 32'(gnt), 32'h0001);
        chk("g0_id", 32'(gnt_id), 32'h0);
        chk("g0_valid", 32'(gnt_valid), 32'h1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("rel0_gnt", 32'(gnt), 32'h0);
        chk("rel0_valid", 32'(gnt_valid), 32'h0);
        chk("rel0_to", 32'(timeout), 32'h0);
        tick();
        chk("g1_id", 32'(gnt_id), 32'd15);
        chk("g1_gnt", 32'(gnt), 32'h8000);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("rel1_gnt", 32'(gnt), 32'h0);
        tick();
        chk("g2_id", 32'(gnt_id), 32'h0);
        chk("g2_gnt", 32'(gnt), 32'h0001);
        req = 16'h0000;
        tick();
        chk("drop_gnt", 32'(gnt), 32'h0);
        chk("drop_to", 32'(timeout), 32'h0);

        // single persistent requester ages out after HOLD_MAX cycles
        req = 16'h0020;
        tick();
        chk("to_first_gnt", 32'(gnt), 32'h0020);
        chk("to_first_id", 32'(gnt_id), 32'd5);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_hold_gnt", 32'(gnt), 32'h0020);
            chk("to_hold_to", 32'(timeout), 32'h0);
        end
        tick();
        chk("to_rel_gnt", 32'(gnt), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        tick();
        chk("regrant_gnt", 32'(gnt), 32'h0020);
        chk("regrant_id", 32'(gnt_id), 32'd5);
        chk("to_clear", 32'(timeout), 32'h0);

        // done coincides with hold limit: normal release, no timeout
        repeat (7) tick();
        chk("both_pre_gnt", 32'(gnt), 32'h0020);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("both_gnt", 32'(gnt), 32'h0);
        chk("both_to", 32'(timeout), 32'h0);
        req = 16'h0000;
        tick();
        chk("both_idle_gnt", 32'(gnt), 32'h0);
        chk("both_idle_flag", 32'(idle_flag), 32'h1);

        // grantee 3 drops its request while 7 waits
        req = 16'h0008;
        tick();
        chk("g3_id", 32'(gnt_id), 32'd3);
        req = 16'h0088;
        tick();
        chk("g3_hold", 32'(gnt), 32'h0008);
        req = 16'h0080;
        tick();
        chk("g3_rel", 32'(gnt), 32'h0);
        chk("g3_rel_to", 32'(timeout), 32'h0);
        tick();
        chk("g7_id", 32'(gnt_id), 32'd7);
        chk("g7_gnt", 32'(gnt), 32'h0080);

        // en low during a grant blocks only the next grant
        en  = 1'b0;
        req = 16'h0480;
        tick();
        chk("en0_hold", 32'(gnt), 32'h0080);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("en0_rel", 32'(gnt), 32'h0);
        tick();
        tick();
        chk("en0_block", 32'(gnt), 32'h0);
        chk("en0_valid", 32'(gnt_valid), 32'h0);
        chk("en0_idleflag", 32'(idle_flag), 32'h0);
        en = 1'b1;
        tick();
        chk("en1_id", 32'(gnt_id), 32'd10);
        chk("en1_gnt", 32'(gnt), 32'h0400);

        // reset during a grant to 9; pointer returns to N-1
        req = 16'h0000;
        tick();
        chk("g10_rel", 32'(gnt), 32'h0);
        req = 16'h0200;
        tick();
        chk("g9_id", 32'(gnt_id), 32'd9);
        req = 16'h1200;
        rst = 1'b1;
        tick();
        chk("rstg_gnt", 32'(gnt), 32'h0);
        chk("rstg_valid", 32'(gnt_valid), 32'h0);
        chk("rstg_id", 32'(gnt_id), 32'h0);
        chk("rstg_to", 32'(timeout), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_id", 32'(gnt_id), 32'd9);
        chk("post_rst_gnt", 32'(gnt), 32'h0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 16: number of requesters; gnt_id width is 4, so N SHALL be between 2 and 16.
REQ-002 Parameter HOLD_MAX, default 8: maximum number of cycles one grant may last; legal range is 1..15.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  arbitration enable; when low, no new grant is issued.
REQ-006 req  input  N  request vector; bit i high means requester i wants the shared resource.
REQ-007 done  input  1  the current grantee releases the resource; sampled only in state GRANT.
REQ-008 gnt  output  N  one-hot grant vector, registered.
REQ-009 gnt_id  output  4  binary index of the current grantee, registered; 4'd0 when gnt_valid is low.
REQ-010 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-011 timeout  output  1  one-cycle pulse: a grant was revoked because HOLD_MAX was reached.
REQ-012 idle_flag  output  1  high when the FSM is in IDLE and req is all-zero.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-014 State register: ptr (4 bits), the index of the last requester granted.
REQ-015 State register: hold_cnt (4 bits), the grant-age counter.
REQ-016 IDLE, with en=1 and req!=0: select the first set req bit scanning from index ptr+1 upward, wrapping from N-1 to 0, and ending at ptr inclusive.
REQ-017 The selection in REQ-016 SHALL load gnt, gnt_id and gnt_valid and move the FSM to GRANT on the same edge, so latency from req sampled to gnt visible is 1 cycle.
REQ-018 IDLE, with en=0 or req==0: gnt stays 0 and the FSM stays in IDLE.
REQ-019 On entering GRANT, hold_cnt SHALL load 1; it increments by 1 on each subsequent cycle spent in GRANT.
REQ-020 GRANT release conditions (any one is sufficient): done=1; req[gnt_id]=0; or hold_cnt==HOLD_MAX.
REQ-021 On the release edge: gnt and gnt_id clear to 0, gnt_valid goes low, ptr loads gnt_id, the FSM returns to IDLE, and hold_cnt clears to 0.
REQ-022 At least one cycle SHALL separate consecutive grants, because grants are only issued from IDLE.
REQ-023 timeout SHALL pulse for one cycle, coincident with the first IDLE cycle, only when the release was caused solely by hold_cnt==HOLD_MAX.
REQ-024 If done=1 or the grantee's req drops on the same cycle that hold_cnt==HOLD_MAX, the release is treated as normal and timeout stays low.
REQ-025 en going low while in GRANT SHALL NOT revoke the current grant; it only blocks the next grant.
REQ-026 Requests from non-granted requesters SHALL be ignored while in GRANT; they are not latched and are re-sampled in IDLE.
REQ-027 With a single persistent requester i, the arbiter SHALL re-grant i after each release, following the wrap rule of REQ-016.
REQ-028 req bits at index N or above (when N<16) do not exist and SHALL never be granted.
REQ-029 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-030 While rst=1 on a clock edge, the FSM SHALL go to IDLE.
REQ-031 While rst=1: gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0.
REQ-032 While rst=1: ptr = N-1, so the first grant after reset scans starting from index 0.
REQ-033 rst asserted during GRANT SHALL drop gnt on that edge, with no timeout pulse.
REQ-034 idle_flag SHALL reflect req combinationally from the first cycle after reset.
REQ-035 rst SHALL take priority over every other input.

Verification
REQ-036 Reset then req=16'h8001, en=1, done pulsed in each grant's 2nd cycle -> first grant gnt_id=0, next grant gnt_id=15, next gnt_id=0; one IDLE cycle between each grant.
REQ-037 Single requester: req=16'h0020 held, done never asserted, HOLD_MAX=8 -> gnt=16'h0020 for exactly 8 cycles, then a 1-cycle timeout pulse with gnt=0, then re-grant to id 5.
REQ-038 Simultaneous done=1 and hold_cnt==HOLD_MAX -> release occurs, timeout stays 0.
REQ-039 Grantee id 3 drops req mid-grant while req[7]=1 -> gnt clears on the next edge, and gnt_id=7 one IDLE cycle later.
REQ-040 en=0 asserted in GRANT with other requests pending -> current grant completes normally; no further grant while en=0; arbitration resumes one cycle after en=1.
REQ-041 rst pulsed during a grant to id 9 -> gnt=0 the next cycle, and the next grant goes to the lowest set req index (ptr reset to N-1).
